// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   state_t          - arbiter FSM states
//   NUM_REQ          - requester count (fixed at 4 in this revision)
//   ID_W             - width of a requester index
//   BUSY_TO_DEFAULT  - default cycles to wait for the transmitter to go busy
package uart_pkg;

  localparam int NUM_REQ         = 4;
  localparam int ID_W            = 2;
  localparam int BUSY_TO_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_priority_sel.sv
// rr_priority_sel: combinational round-robin winner selection with lock hold.
//   req        - per-requester pending request
//   last_grant - index of the previous winner; search starts one past it
//   lock       - per-requester hold request; only lock[last_grant] matters
//   winner     - selected requester index (meaningful when found=1)
//   found      - at least one requester is pending
module rr_priority_sel #(
  parameter int NUM_REQ = uart_pkg::NUM_REQ
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [uart_pkg::ID_W-1:0] last_grant,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [uart_pkg::ID_W-1:0] winner,
  output logic                      found
);
  import uart_pkg::*;

  // cand[k] is the requester examined at search position k: last_grant+1+k.
  logic [ID_W-1:0] cand [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ID_W'((int'(last_grant) + gi + 1) % NUM_REQ);
    end
  endgenerate

  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    if (lock[last_grant] && req[last_grant]) begin
      // A locked owner with another byte pending keeps the transmitter.
      winner = last_grant;
      found  = 1'b1;
    end else begin
      // Scan from the far end so the nearest pending candidate is assigned last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req[cand[i]]) begin
          winner = cand[i];
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources.
//   CLK, rst   - clock (rising edge) and synchronous active-high reset
//   req        - per-requester byte pending (level, sampled only in IDLE)
//   lock       - per-requester hold-grant for multi-byte packets
//   req_data   - packed bytes, requester i at [i*Width +: Width]
//   Busy       - transmitter busy flag
//   P_data     - byte to the transmitter, held until the next selection
//   Data_valid - one-cycle launch strobe (high during ISSUE)
//   ack        - one-hot byte-accepted pulse, coincident with Data_valid
//   grant_id   - current or most recent owner
//   arb_busy   - high whenever the FSM is not in IDLE
//   tx_err     - one-cycle pulse when Busy never rose after a launch
module uart_tx_arbiter #(
  parameter int Width   = 8,
  parameter int NUM_REQ = uart_pkg::NUM_REQ,
  parameter int BUSY_TO = uart_pkg::BUSY_TO_DEFAULT
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*Width-1:0]  req_data,
  input  logic                      Busy,
  output logic [Width-1:0]          P_data,
  output logic                      Data_valid,
  output logic [NUM_REQ-1:0]        ack,
  output logic [uart_pkg::ID_W-1:0] grant_id,
  output logic                      arb_busy,
  output logic                      tx_err
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(BUSY_TO + 1);

  state_t          state_reg;
  logic [ID_W-1:0] last_grant_reg;
  logic [CNT_W-1:0] to_cnt_reg;

  logic [ID_W-1:0] winner;
  logic            found;

  logic [Width-1:0] req_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*Width +: Width];
    end
  endgenerate

  rr_priority_sel #(
    .NUM_REQ(NUM_REQ)
  ) u_sel (
    .req       (req),
    .last_grant(last_grant_reg),
    .lock      (lock),
    .winner    (winner),
    .found     (found)
  );

  // All outputs are registered; Data_valid/ack are set on the IDLE->ISSUE
  // edge so they are high exactly while the FSM sits in ISSUE.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      to_cnt_reg     <= '0;
      P_data         <= '0;
      Data_valid     <= 1'b0;
      ack            <= '0;
      grant_id       <= '0;
      arb_busy       <= 1'b0;
      tx_err         <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      ack        <= '0;
      tx_err     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            P_data         <= req_bytes[winner];
            grant_id       <= winner;
            last_grant_reg <= winner;
            Data_valid     <= 1'b1;
            ack            <= NUM_REQ'(1) << winner;
            arb_busy       <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt_reg <= '0;
          state_reg  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (Busy) begin
            to_cnt_reg <= '0;
            state_reg  <= WAIT_DONE;
          end else if (to_cnt_reg == CNT_W'(BUSY_TO - 1)) begin
            // This cycle would bring the count to BUSY_TO: give up, no retry.
            to_cnt_reg <= '0;
            tx_err     <= 1'b1;
            arb_busy   <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!Busy) begin
            arb_busy  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          arb_busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a launch scoreboard for uart_tx_arbiter.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] req_data;
  logic        Busy;
  logic [7:0]  P_data;
  logic        Data_valid;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        tx_err;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   err_pulses = 0;
  int   busy_cnt   = 0;
  bit   tx_mode    = 1'b1;   // 1: transmitter answers a launch with a 10-cycle frame

  uart_tx_arbiter dut (
    .CLK       (CLK),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .req_data  (req_data),
    .Busy      (Busy),
    .P_data    (P_data),
    .Data_valid(Data_valid),
    .ack       (ack),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .tx_err    (tx_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Transmitter model: busy for 10 cycles starting the edge after a launch.
  always @(posedge CLK) begin
    if (rst)                         busy_cnt <= 0;
    else if (tx_mode && Data_valid)  busy_cnt <= 10;
    else if (busy_cnt > 0)           busy_cnt <= busy_cnt - 1;
  end
  assign Busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every launch must match the oldest expectation.
  always @(negedge CLK) begin
    if (!rst) begin
      if (tx_err) err_pulses++;
      if (Data_valid) begin
        check("dv_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("launch: grant_id=%0d P_data=%02h ack=%b (exp id=%0d data=%02h)",
                   grant_id, P_data, ack, e.id, e.data);
          check("sb_grant_id", grant_id, e.id);
          check("sb_P_data",   P_data,   e.data);
          check("sb_ack",      ack,      4'b0001 << e.id);
        end
      end else begin
        check("ack_idle", ack, 4'b0000);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_size(input string tag, input int target, input int budget);
    int n = 0;
    while (sb.size() > target && n < budget) begin
      tick();
      n++;
    end
    check(tag, sb.size(), target);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (arb_busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, arb_busy, 1'b0);
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int n = 0;
    while (!Data_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, Data_valid, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    lock     = '0;
    req_data = '0;

    // Reset state and single-request latency.
    do_reset();
    check("rst_P_data",     P_data,     8'h00);
    check("rst_Data_valid", Data_valid, 1'b0);
    check("rst_ack",        ack,        4'b0000);
    check("rst_grant_id",   grant_id,   2'd0);
    check("rst_arb_busy",   arb_busy,   1'b0);
    check("rst_tx_err",     tx_err,     1'b0);
    push(2'd0, 8'hA5);
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    check("lat_cycle1_dv", Data_valid, 1'b0);
    tick();
    check("lat_cycle2_dv",  Data_valid, 1'b1);
    check("lat_P_data",     P_data,     8'hA5);
    check("lat_ack",        ack,        4'b0001);
    check("lat_grant_id",   grant_id,   2'd0);
    req = 4'b0000;
    wait_idle("single_idle", 40);
    check("single_sb_empty", sb.size(), 0);

    // All four requesting: round-robin 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) push(2'(i % 4), 8'h10 + 8'(i % 4));
    req_data = 32'h1312_1110;
    req      = 4'b1111;
    wait_size("rr_drain", 0, 120);
    req = 4'b0000;
    wait_idle("rr_idle", 40);

    // Lock holds requester 1 for three bytes, then round-robin moves to 2.
    do_reset();
    push(2'd1, 8'h21);
    push(2'd1, 8'h21);
    push(2'd1, 8'h21);
    push(2'd2, 8'h22);
    req_data = 32'h0022_2100;
    lock     = 4'b0010;
    req      = 4'b0110;
    wait_size("lock_three", 1, 100);
    lock = 4'b0000;
    wait_size("lock_release", 0, 40);
    req = 4'b0000;
    wait_idle("lock_idle", 40);

    // Busy never rises: one launch, tx_err three cycles into WAIT_BUSY.
    do_reset();
    tx_mode = 1'b0;
    push(2'd2, 8'h3C);
    req_data = 32'h003C_0000;
    req      = 4'b0100;
    wait_dv("tmo_dv", 10);
    req = 4'b0000;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check($sformatf("tmo_tx_err_t%0d", t), tx_err, 1'(t == 4));
      check($sformatf("tmo_arb_busy_t%0d", t), arb_busy, 1'(t < 4));
    end
    check("tmo_err_count", err_pulses, 1);
    tx_mode = 1'b1;

    // Reset while in WAIT_DONE abandons the byte; requester 0 wins next.
    do_reset();
    push(2'd1, 8'h5A);
    req_data = 32'h0000_5A00;
    req      = 4'b0010;
    wait_dv("rstwd_dv", 10);
    req = 4'b0000;
    tick();
    tick();
    tick();
    check("rstwd_in_wait", arb_busy, 1'b1);
    rst = 1'b1;
    tick();
    check("rstwd_P_data",     P_data,     8'h00);
    check("rstwd_Data_valid", Data_valid, 1'b0);
    check("rstwd_ack",        ack,        4'b0000);
    check("rstwd_grant_id",   grant_id,   2'd0);
    check("rstwd_arb_busy",   arb_busy,   1'b0);
    check("rstwd_tx_err",     tx_err,     1'b0);
    rst = 1'b0;
    push(2'd0, 8'h77);
    req_data = 32'h4433_2277;
    req      = 4'b1111;
    wait_size("rstwd_next", 0, 20);
    req = 4'b0000;
    wait_idle("rstwd_idle", 40);
    check("rstwd_err_count", err_pulses, 1);

    // req toggling during WAIT_DONE must not launch anything.
    do_reset();
    push(2'd0, 8'h99);
    req_data = 32'h0000_0099;
    req      = 4'b0001;
    wait_dv("tog_dv", 10);
    req = 4'b0000;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      req = (i % 2 == 0) ? 4'b1010 : 4'b0101;
      tick();
      check($sformatf("tog_no_dv_%0d", i), Data_valid, 1'b0);
    end
    req = 4'b0000;
    wait_idle("tog_idle", 40);
    repeat (3) tick();
    check("tog_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter Width, default 8: byte width forwarded to the UART transmitter.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters (fixed at 4 in this revision; ID width 2).
REQ-003 The block SHALL have parameter BUSY_TO, default 3: maximum cycles to wait for transmitter Busy to rise after a launch.
REQ-004 The block SHALL have port CLK, input, 1: single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, NUM_REQ: per-requester byte-pending request, level.
REQ-007 The block SHALL have port lock, input, NUM_REQ: per-requester hold-grant request for multi-byte packets.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*Width: packed bytes, requester i at bits [i*Width +: Width].
REQ-009 The block SHALL have port Busy, input, 1: transmitter busy flag.
REQ-010 The block SHALL have port P_data, output, Width: byte to transmitter.
REQ-011 The block SHALL have port Data_valid, output, 1: one-cycle launch strobe to transmitter.
REQ-012 The block SHALL have port ack, output, NUM_REQ: one-hot, one-cycle byte-accepted pulse.
REQ-013 The block SHALL have port grant_id, output, 2: index of the current or most recent owner.
REQ-014 The block SHALL have port arb_busy, output, 1: high in every state except IDLE.
REQ-015 The block SHALL have port tx_err, output, 1: one-cycle pulse on Busy timeout.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE with req==0, the block SHALL remain in IDLE.
REQ-018 In IDLE with req!=0, the block SHALL select a winner, latch its req_data into P_data, set grant_id to the winner, and move to ISSUE, all in one cycle.
REQ-019 Winner selection SHALL be round-robin, with the search starting at (last_grant+1) mod NUM_REQ.
REQ-020 Lock override: if lock[last_grant] and req[last_grant] are both high in IDLE, last_grant SHALL win regardless of the round-robin order.
REQ-021 last_grant SHALL update to the winner on every selection.
REQ-022 ISSUE SHALL last exactly one cycle and assert Data_valid=1 and ack[grant_id]=1, then move to WAIT_BUSY.
REQ-023 Latency from req rising in IDLE to Data_valid SHALL be 2 cycles.
REQ-024 P_data SHALL hold stable from latch until the next selection.
REQ-025 In WAIT_BUSY, Busy==1 SHALL move the block to WAIT_DONE and clear the timeout counter.
REQ-026 The WAIT_BUSY timeout counter SHALL increment every cycle; when it reaches BUSY_TO, the block SHALL pulse tx_err for one cycle and return to IDLE with no retry.
REQ-027 In WAIT_DONE, Busy==0 SHALL move the block to IDLE; otherwise it SHALL remain in WAIT_DONE with no timeout.
REQ-028 Minimum spacing between consecutive Data_valid pulses SHALL be 4 cycles.
REQ-029 req and lock SHALL be sampled only in IDLE; changes in other states SHALL have no effect.
REQ-030 After ack, a requester SHALL update req_data/req for its next byte before the block returns to IDLE; a req still high in IDLE is treated as a new byte.
REQ-031 Simultaneous requests SHALL be resolved by round-robin; exactly one ack SHALL be asserted per launch.
REQ-032 A lock on a requester that is not last_grant SHALL be ignored.
REQ-033 lock without req SHALL NOT hold the grant; normal round-robin SHALL apply.

Reset
REQ-034 While rst=1 at a rising CLK edge: state=IDLE, P_data=0, Data_valid=0, ack=0, grant_id=0, arb_busy=0, tx_err=0, timeout counter=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-035 Reset mid-operation SHALL abandon the byte in flight with no ack or tx_err; the transmitter is reset by the same rst.

Structure
REQ-036 The package uart_pkg SHALL hold the state enumeration, NUM_REQ, BUSY_TO default, and ID width.
REQ-037 The block SHALL contain one combinational sub-module, rr_priority_sel (inputs req, last_grant, lock; outputs winner, found).
REQ-038 The FSM, data latch and timeout counter SHALL reside in uart_tx_arbiter.

Verification
REQ-039 The bench SHALL check: after reset, req=4'b0001 with data 0xA5 -> Data_valid on 2nd cycle, P_data=0xA5, ack=4'b0001, grant_id=0.
REQ-040 The bench SHALL check: req=4'b1111 held with Busy modelled as 10-cycle frames -> grant order 0,1,2,3,0 and one ack per launch.
REQ-041 The bench SHALL check: req=4'b0110 with lock[1]=1 for 3 bytes -> grants 1,1,1, then 2 after lock drops.
REQ-042 The bench SHALL check: Busy tied 0, req[2]=1 -> Data_valid once, tx_err pulse exactly 3 cycles into WAIT_BUSY, then return to IDLE.
REQ-043 The bench SHALL check: rst asserted during WAIT_DONE -> next cycle all outputs 0, state IDLE, and next grant to requester 0.
REQ-044 The bench SHALL check: req toggled during WAIT_DONE -> no extra Data_valid and no ack until IDLE.
